// File: rtl/sha256_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_seq_pkg
// Description : Shared types and constants for the SHA-256 stream sequencer:
//               FSM state encoding, block geometry, pad byte, and the
//               SHA-256 digest of the empty message.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_PAD   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    localparam int         BLOCK_WORDS = 16;
    localparam int         LEN_HI_IDX  = 14;
    localparam int         LEN_LO_IDX  = 15;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    localparam logic [255:0] SHA256_EMPTY_DIGEST =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    // Final message word: keep the first nbytes bytes, put the pad byte
    // right after them and zero the rest. A full word is returned as-is.
    function automatic logic [31:0] pad_word(input logic [31:0] data,
                                             input logic [2:0]  nbytes);
        logic [31:0] res;
        case (nbytes)
            3'd0:    res = {PAD_BYTE, 24'h0};
            3'd1:    res = {data[31:24], PAD_BYTE, 16'h0};
            3'd2:    res = {data[31:16], PAD_BYTE, 8'h0};
            3'd3:    res = {data[31:8], PAD_BYTE};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_msg_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_buffer
// Description : 16 x 32-bit message block register file. Accepts stream
//               words (with byte masking and pad marker on the last word)
//               and a one-shot pad operation that zero-fills the tail,
//               optionally places a full 0x80000000 marker word and inserts
//               the 64-bit message length into words 14/15.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_buffer
    import sha256_seq_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en_i,
    input  logic [3:0]   wr_idx_i,
    input  logic [31:0]  wr_data_i,
    input  logic         wr_last_i,
    input  logic [2:0]   wr_bytes_i,
    input  logic         pad_en_i,
    input  logic [4:0]   pad_from_i,
    input  logic         mark_en_i,
    input  logic         len_en_i,
    input  logic [63:0]  len_i,
    output logic [511:0] block_o
);

    logic [31:0] mem_q [BLOCK_WORDS];

    // Word writes from the stream, or a whole-block pad pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                if (wr_en_i && (wr_idx_i == 4'(i))) begin
                    mem_q[i] <= wr_last_i ? pad_word(wr_data_i, wr_bytes_i) : wr_data_i;
                end else if (pad_en_i) begin
                    if (len_en_i && (i == LEN_HI_IDX)) begin
                        mem_q[i] <= len_i[63:32];
                    end else if (len_en_i && (i == LEN_LO_IDX)) begin
                        mem_q[i] <= len_i[31:0];
                    end else if (5'(i) >= pad_from_i) begin
                        mem_q[i] <= (mark_en_i && (5'(i) == pad_from_i)) ? {PAD_BYTE, 24'h0} : 32'h0;
                    end
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_pack
            assign block_o[511-32*g -: 32] = mem_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sha256_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sha256_stream_sequencer
// Description : Front-end for a SHA-256 core. Packs a 32-bit word stream
//               into 512-bit blocks, applies padding and the length field,
//               drives the core init/next handshake (including one or two
//               trailing pad blocks) and registers the final digest.
//               Optional block/message counters: SHA256_SEQ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_stream_sequencer
    import sha256_seq_pkg::*;
#(
    parameter int LEN_W = 64
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic [2:0]   s_bytes,
    output logic         core_init,
    output logic         core_next,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic [255:0] core_digest,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
`ifdef SHA256_SEQ_STATS_EN
    ,
    output logic [31:0]  blk_count,
    output logic [31:0]  msg_count
`endif
);

    seq_state_t       state_q;
    logic [4:0]       idx_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic             first_blk_q;
    logic             final_q;
    logic             pend_q;
    logic             pend_mark_q;
    logic [4:0]       pad_from_q;
    logic             mark_full_q;
    logic             wait_first_q;
    logic             s_ready_q;
    logic             core_init_q;
    logic             core_next_q;
    logic [255:0]     digest_q;
    logic             digest_valid_q;
    logic             busy_q;

    logic             w_accept;
    logic [4:0]       w_mark_idx;
    logic             w_pad_final;
    logic             w_issue_fire;
    logic             w_wait_done;

    assign w_accept     = s_valid && s_ready_q;
    assign len_d        = len_q + (s_last ? LEN_W'({s_bytes, 3'b000}) : LEN_W'(32));
    // A full last word pushes the marker into the following word
    assign w_mark_idx   = mark_full_q ? pad_from_q : (pad_from_q - 5'd1);
    // The length fits only if the marker leaves words 14/15 free
    assign w_pad_final  = pend_q || (w_mark_idx < 5'(LEN_HI_IDX));
    assign w_issue_fire = (state_q == ST_ISSUE) && core_ready;
    assign w_wait_done  = (state_q == ST_WAIT) && !wait_first_q && core_ready;

    sha256_msg_buffer u_buf (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (w_accept),
        .wr_idx_i   (idx_q[3:0]),
        .wr_data_i  (s_data),
        .wr_last_i  (s_last),
        .wr_bytes_i (s_bytes),
        .pad_en_i   (state_q == ST_PAD),
        .pad_from_i (pend_q ? 5'd0 : pad_from_q),
        .mark_en_i  (pend_q ? pend_mark_q : mark_full_q),
        .len_en_i   (w_pad_final),
        .len_i      (64'(len_q)),
        .block_o    (core_block)
    );

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            len_q          <= '0;
            first_blk_q    <= 1'b1;
            final_q        <= 1'b0;
            pend_q         <= 1'b0;
            pend_mark_q    <= 1'b0;
            pad_from_q     <= '0;
            mark_full_q    <= 1'b0;
            wait_first_q   <= 1'b0;
            s_ready_q      <= 1'b0;
            core_init_q    <= 1'b0;
            core_next_q    <= 1'b0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            core_init_q    <= 1'b0;
            core_next_q    <= 1'b0;
            digest_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    s_ready_q <= 1'b1;
                    if (w_accept) begin
                        busy_q <= 1'b1;
                        idx_q  <= idx_q + 5'd1;
                        len_q  <= len_d;
                        if (s_last) begin
                            state_q     <= ST_PAD;
                            s_ready_q   <= 1'b0;
                            pad_from_q  <= idx_q + 5'd1;
                            mark_full_q <= (s_bytes >= 3'd4);
                            pend_q      <= 1'b0;
                        end else if (idx_q == 5'(BLOCK_WORDS - 1)) begin
                            state_q   <= ST_ISSUE;
                            s_ready_q <= 1'b0;
                            final_q   <= 1'b0;
                            pend_q    <= 1'b0;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                ST_PAD: begin
                    final_q     <= w_pad_final;
                    pend_q      <= !w_pad_final;
                    pend_mark_q <= mark_full_q && (pad_from_q == 5'(BLOCK_WORDS));
                    state_q     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (core_ready) begin
                        core_init_q  <= first_blk_q;
                        core_next_q  <= !first_blk_q;
                        first_blk_q  <= 1'b0;
                        wait_first_q <= 1'b1;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_first_q <= 1'b0;
                    if (w_wait_done) begin
                        if (final_q) begin
                            digest_q       <= core_digest;
                            digest_valid_q <= 1'b1;
                            busy_q         <= 1'b0;
                            state_q        <= ST_DONE;
                        end else if (pend_q) begin
                            state_q <= ST_PAD;
                        end else begin
                            idx_q     <= '0;
                            s_ready_q <= 1'b1;
                            state_q   <= ST_FILL;
                        end
                    end
                end
                ST_DONE: begin
                    first_blk_q <= 1'b1;
                    len_q       <= '0;
                    idx_q       <= '0;
                    pend_q      <= 1'b0;
                    s_ready_q   <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign core_init    = core_init_q;
    assign core_next    = core_next_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign busy         = busy_q;

`ifdef SHA256_SEQ_STATS_EN
    logic [31:0] blk_count_q;
    logic [31:0] msg_count_q;

    // Saturating counters of issued blocks and completed digests
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_count_q <= '0;
            msg_count_q <= '0;
        end else begin
            if (w_issue_fire && (blk_count_q != 32'hFFFF_FFFF)) begin
                blk_count_q <= blk_count_q + 32'd1;
            end
            if (w_wait_done && final_q && (msg_count_q != 32'hFFFF_FFFF)) begin
                msg_count_q <= msg_count_q + 32'd1;
            end
        end
    end

    assign blk_count = blk_count_q;
    assign msg_count = msg_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_stream_sequencer
// Description : Directed self-checking bench for sha256_stream_sequencer with
//               a behavioural SHA-256 core attached to the core_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_stream_sequencer;
    import sha256_seq_pkg::*;

    localparam int LAT = 8;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] Q56_DIGEST =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h18};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] Q56 [14] = '{
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
        32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071
    };

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_last = 1'b0;
    logic [2:0]   s_bytes = '0;
    logic         hold_low = 1'b0;
    logic         s_ready;
    logic         core_init;
    logic         core_next;
    logic [511:0] core_block;
    logic         core_ready;
    logic [255:0] core_digest;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
`ifdef SHA256_SEQ_STATS_EN
    logic [31:0]  blk_count;
    logic [31:0]  msg_count;
`endif

    int checks = 0;
    int failures = 0;

    sha256_stream_sequencer #(.LEN_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_bytes      (s_bytes),
        .core_init    (core_init),
        .core_next    (core_next),
        .core_block   (core_block),
        .core_ready   (core_ready),
        .core_digest  (core_digest),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy)
`ifdef SHA256_SEQ_STATS_EN
        ,
        .blk_count    (blk_count),
        .msg_count    (msg_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-7] + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Behavioural SHA-256 core: ready drops the edge after a pulse, returns LAT cycles later
    logic         m_ready = 1'b1;
    int           m_cnt = 0;
    logic [255:0] m_h = '0;
    always @(posedge clk) begin
        if (core_init || core_next) begin
            m_h     <= sha_compress(core_init ? IV : m_h, core_block);
            m_ready <= 1'b0;
            m_cnt   <= LAT;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_ready <= 1'b1;
        end
    end
    assign core_ready  = m_ready && !hold_low;
    assign core_digest = m_h;

    // Log of every issued block and pulse kind
    int           n_init = 0;
    int           n_next = 0;
    logic [511:0] blk_log [64];
    always @(posedge clk) begin
        if (core_init || core_next) begin
            blk_log[(n_init + n_next) % 64] <= core_block;
            if (core_init) n_init <= n_init + 1;
            else           n_next <= n_next + 1;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = last; s_bytes = nb;
        while (s_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (s_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL beat_timeout: s_ready=%b required 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic end_stream();
        s_valid = 1'b0; s_last = 1'b0; s_bytes = '0;
    endtask

    task automatic wait_digest(input string nm, input logic [255:0] exp_d);
        int t = 0;
        @(negedge clk);
        while (digest_valid !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (digest_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: digest_valid=%b required 1", nm, digest_valid);
        end else begin
            checks++;
            if (digest !== exp_d) begin
                failures++;
                $display("FAIL %s_digest: got %h required %h", nm, digest, exp_d);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s_busy_at_valid: got %b required 0", nm, busy);
            end
            @(negedge clk);
            checks++;
            if (digest_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_valid_pulse: got %b required 0", nm, digest_valid);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, core_init, core_next, digest_valid, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 00000", {s_ready, core_init, core_next, digest_valid, busy});
        end
        checks++;
        if (core_block !== 512'h0) begin
            failures++;
            $display("FAIL reset_block: got %h required 0", core_block);
        end
        checks++;
        if (digest !== 256'h0) begin
            failures++;
            $display("FAIL reset_digest: got %h required 0", digest);
        end
`ifdef SHA256_SEQ_STATS_EN
        checks++;
        if (blk_count !== 32'd0 || msg_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_stats: got %0d/%0d required 0/0", blk_count, msg_count);
        end
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready: got %b required 1", s_ready);
        end
    endtask

    task automatic test_abc();
        int bi = n_init; int bn = n_next;
        send_beat(32'h61626300, 1'b1, 3'd3);
        end_stream();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL abc_busy_ready: got %b%b required 10", busy, s_ready);
        end
        wait_digest("abc", ABC_DIGEST);
        checks++;
        if ((n_init - bi) != 1 || (n_next - bn) != 0) begin
            failures++;
            $display("FAIL abc_pulses: got init=%0d next=%0d required 1/0", n_init - bi, n_next - bn);
        end
        checks++;
        if (blk_log[bi + bn] !== ABC_BLOCK) begin
            failures++;
            $display("FAIL abc_block: got %h required %h", blk_log[bi + bn], ABC_BLOCK);
        end
    endtask

    task automatic test_two_block_pad();
        int bi = n_init; int bn = n_next;
        logic [511:0] e1;
        logic [511:0] e2;
        for (int i = 0; i < 14; i++) e1[511-32*i -: 32] = Q56[i];
        e1[63:0] = {32'h80000000, 32'h0};
        e2 = {480'h0, 32'h1C0};
        for (int i = 0; i < 14; i++) send_beat(Q56[i], i == 13, (i == 13) ? 3'd4 : 3'd0);
        end_stream();
        wait_digest("q56", Q56_DIGEST);
        checks++;
        if ((n_init - bi) != 1 || (n_next - bn) != 1) begin
            failures++;
            $display("FAIL q56_pulses: got init=%0d next=%0d required 1/1", n_init - bi, n_next - bn);
        end
        checks++;
        if (blk_log[bi + bn] !== e1) begin
            failures++;
            $display("FAIL q56_block1: got %h required %h", blk_log[bi + bn], e1);
        end
        checks++;
        if (blk_log[bi + bn + 1] !== e2) begin
            failures++;
            $display("FAIL q56_block2: got %h required %h", blk_log[bi + bn + 1], e2);
        end
    endtask

    task automatic test_empty();
        int bi = n_init; int bn = n_next;
        logic [511:0] e1;
        e1 = {32'h80000000, 480'h0};
        send_beat(32'hDEADBEEF, 1'b1, 3'd0);
        end_stream();
        wait_digest("empty", SHA256_EMPTY_DIGEST);
        checks++;
        if (blk_log[bi + bn] !== e1 || (n_init - bi) != 1) begin
            failures++;
            $display("FAIL empty_block: got %h init=%0d required %h init=1", blk_log[bi + bn], n_init - bi, e1);
        end
    endtask

    task automatic test_back_to_back_full();
        int bi = n_init; int bn = n_next;
        logic [511:0] e1;
        logic [511:0] e2;
        logic [31:0]  wd;
        for (int i = 0; i < 16; i++) e1[511-32*i -: 32] = 32'h00112233 + 32'h01010101 * i;
        e2 = {32'h80000000, 448'h0, 32'h200};
        for (int i = 0; i < 16; i++) begin
            wd = 32'h00112233 + 32'h01010101 * i;
            send_beat(wd, i == 15, (i == 15) ? 3'd4 : 3'd0);
        end
        end_stream();
        wait_digest("full64", sha_compress(sha_compress(IV, e1), e2));
        checks++;
        if ((n_init - bi) != 1 || (n_next - bn) != 1) begin
            failures++;
            $display("FAIL full64_pulses: got init=%0d next=%0d required 1/1", n_init - bi, n_next - bn);
        end
        checks++;
        if (blk_log[bi + bn] !== e1) begin
            failures++;
            $display("FAIL full64_block1: got %h required %h", blk_log[bi + bn], e1);
        end
        checks++;
        if (blk_log[bi + bn + 1] !== e2) begin
            failures++;
            $display("FAIL full64_block2: got %h required %h", blk_log[bi + bn + 1], e2);
        end
    endtask

    task automatic test_backpressure();
        int bi = n_init; int bn = n_next;
        int bad_ready = 0; int bad_issue = 0;
        hold_low = 1'b1;
        send_beat(32'h61626300, 1'b1, 3'd3);
        end_stream();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready !== 1'b0) bad_ready++;
            if ((n_init + n_next) != (bi + bn)) bad_issue++;
        end
        checks++;
        if (bad_ready != 0) begin
            failures++;
            $display("FAIL bp_ready: got %0d cycles with s_ready high required 0", bad_ready);
        end
        checks++;
        if (bad_issue != 0) begin
            failures++;
            $display("FAIL bp_issue: got %0d cycles after early pulse required 0", bad_issue);
        end
        hold_low = 1'b0;
        wait_digest("bp", ABC_DIGEST);
        checks++;
        if ((n_init - bi) != 1 || (n_next - bn) != 0 || blk_log[bi + bn] !== ABC_BLOCK) begin
            failures++;
            $display("FAIL bp_issue_after: got init=%0d next=%0d required 1/0 with abc block", n_init - bi, n_next - bn);
        end
    endtask

    task automatic test_reset_mid_message();
        int bi = n_init + n_next; int t = 0;
        int b2i; int b2n;
        for (int i = 0; i < 14; i++) send_beat(Q56[i], i == 13, (i == 13) ? 3'd4 : 3'd0);
        end_stream();
        while ((n_init + n_next) == bi && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if ((n_init + n_next) == bi) begin
            failures++;
            $display("FAIL mid_first_issue: got no issue required 1");
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, s_ready, digest_valid} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset_clear: got %b required 000", {busy, s_ready, digest_valid});
        end
        @(negedge clk);
        reset = 1'b0;
        b2i = n_init; b2n = n_next;
        send_beat(32'h61626300, 1'b1, 3'd3);
        end_stream();
        wait_digest("mid_abc", ABC_DIGEST);
        checks++;
        if ((n_init - b2i) != 1 || (n_next - b2n) != 0) begin
            failures++;
            $display("FAIL mid_pulses: got init=%0d next=%0d required 1/0", n_init - b2i, n_next - b2n);
        end
        checks++;
        if (blk_log[b2i + b2n] !== ABC_BLOCK) begin
            failures++;
            $display("FAIL mid_block: got %h required %h", blk_log[b2i + b2n], ABC_BLOCK);
        end
`ifdef SHA256_SEQ_STATS_EN
        checks++;
        if (msg_count !== 32'd1 || blk_count !== 32'd1) begin
            failures++;
            $display("FAIL mid_stats: got msg=%0d blk=%0d required 1/1", msg_count, blk_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_abc();
        test_two_block_pad();
        test_empty();
        test_back_to_back_full();
        test_backpressure();
        test_reset_mid_message();
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha256_stream_sequencer.md
Name: sha256_stream_sequencer

Overview:
Front-end controller for the SHA-256 core. It accepts a byte-packed 32-bit message word stream and assembles 512-bit blocks. It applies the SHA-256 padding and 64-bit length field. It drives the core's init/next/block handshake, sequencing one or two trailing pad blocks as needed, and registers the final digest. The core's ports connect directly to this block's core_* ports.

Parameters:
LEN_W, 64, width of the internal message bit-length counter; zero-extended to 64 bits in the length field; legal range 16..64.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid && s_ready
s_data  in  32  message word, big-endian (first byte in [31:24])
s_last  in  1  final word of message
s_bytes  in  3  valid bytes in the s_last word, 1..4; 0 only on a lone s_last beat, meaning an empty message
core_init  out  1  one-cycle pulse, first block
core_next  out  1  one-cycle pulse, subsequent block
core_block  out  512  block to core, word 0 in [511:480]
core_ready  in  1  core idle
core_digest  in  256  core digest
digest  out  256  registered final digest
digest_valid  out  1  one-cycle pulse
busy  out  1  high from first accepted word until digest_valid

Behaviour:
- Reset values: s_ready=0, core_init=0, core_next=0, core_block=0, digest=0, digest_valid=0, busy=0. The FSM goes to IDLE, the word index and length counter are cleared, and first_blk is set to 1.
- FSM states: IDLE, FILL, PAD, ISSUE, WAIT, DONE.
- IDLE: s_ready=1. The first accepted beat moves the FSM to FILL (or to PAD if it is also s_last).
- FILL: s_ready=1 while word index <16.
  - Each beat writes buf[idx], increments idx, and adds 32 to the length (8*s_bytes on s_last).
  - When idx reaches 16 on a non-last beat, go to ISSUE.
  - On s_last, go to PAD.
- PAD, last word: if s_bytes<4, bytes beyond s_bytes are zeroed and byte 0x80 is placed at byte position s_bytes. If s_bytes=4, the 0x80000000 word goes to the next index.
- PAD, remaining words: zero-filled.
  - If the pad marker's word index ≤13, words 14/15 get the 64-bit length and the block is final.
  - Otherwise the current block is issued without length. A second block of zeros, with the length in words 14/15, follows; it is also final.
  - If the marker word index is 16 (i.e. 64n-byte message), the marker begins the second block.
- ISSUE: entered only when core_ready=1, otherwise the FSM holds.
  - The block is driven on core_block (stable from ISSUE through WAIT).
  - core_init pulses if first_blk, else core_next. first_blk is then cleared.
- WAIT:
  - The first cycle ignores core_ready, because the core drops ready one cycle after the pulse.
  - The FSM then waits for core_ready=1.
  - If the block was non-final, go back to FILL (idx=0) or to PAD (pending second pad block).
  - If final, go to DONE.
- DONE: digest<=core_digest and digest_valid pulses for 1 cycle. The FSM returns to IDLE; first_blk=1 and length=0.
- s_ready=0 in PAD/ISSUE/WAIT/DONE. No beat is lost under s_valid held.
- Length counter wraps modulo 2^LEN_W. No error flag.
- Reset mid-message: everything is cleared and the partial message is discarded. The next message always starts with core_init, which is legal after waiting in ISSUE for core_ready.
- Latency, single-block message: last beat → PAD 1 cycle → ISSUE → core cycles → DONE; digest_valid comes 1 cycle after core_ready returns.

Optional Feature:
SHA256_SEQ_STATS_EN.
- Defined: adds outputs blk_count[31:0], which counts issued blocks, and msg_count[31:0], which counts completed digests. Both are cleared by reset and saturate at all-ones.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package sha256_seq_pkg: FSM state enum, BLOCK_WORDS=16, LEN_HI_IDX=14, LEN_LO_IDX=15, PAD_BYTE=8'h80, SHA256 empty-message digest constant for the bench.
- Sub-module sha256_msg_buffer: 16×32 register file with write index, byte masking/pad-marker insertion, length insert and clear. The FSM stays in the top module.

Test Plan:
- Beat 0x61626300, s_last, s_bytes=3 → core_block=61626380_0…0_00000018, single core_init, digest=BA7816BF…F20015AD.
- 14 beats "abcdbcde…nopq" (56 bytes), last s_bytes=4 → two blocks (init, next); second block = 0…01C0; digest=248D6A61…19DB06C1.
- Lone beat, s_last, s_bytes=0 → block 80000000_0…0; digest=E3B0C442…7852B855.
- 16 full beats (64 bytes), last s_last → block1 = data (init), block2 = 80000000_0…0_00000200 (next), exactly 2 issues.
- Backpressure: core_ready held low for 20 cycles before ISSUE → no pulse until ready rises, s_ready=0 throughout, no beat dropped; "abc" digest correct.
- Assert reset during WAIT of a 2-block message, release, then send "abc" → first issue is core_init and digest=BA7816BF…F20015AD; with SHA256_SEQ_STATS_EN, msg_count=1.
